// File: rtl/memory_cycle.sv
// MEM stage of the in-order pipeline: resolves branches/jumps, drives the data bus with an
// IDLE/WAIT handshake FSM (timeout abort), formats store/load data and registers MEM/WB.
module memory_cycle #(
    parameter int TIMEOUT = 15
) (
    input  logic        i_memory_clk,
    input  logic        i_memory_reset,
    input  logic [31:0] i_memory_pc,
    input  logic [31:0] i_memory_inst,
    input  logic        i_memory_insn_vld,
    input  logic        i_memory_ctrl,
    input  logic [31:0] i_memory_alu_data,
    input  logic [31:0] i_memory_rs2_data,
    input  logic        i_memory_br_equal,
    input  logic        i_memory_br_less,
    input  logic        i_memory_lsu_wren,
    input  logic [2:0]  i_memory_slt_sl,
    input  logic [1:0]  i_memory_wb_sel,
    input  logic        i_memory_rd_wren,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_bmask,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_memory_stall,
    output logic        o_memory_flush,
    output logic        o_memory_pc_sel,
    output logic [31:0] o_memory_pc_target,
    output logic        o_memory_misalign,
    output logic        o_memory_bus_err,
    output logic [31:0] o_memory_fwd_data,
    output logic [31:0] o_memory_pc_wb,
    output logic [31:0] o_memory_inst_wb,
    output logic [31:0] o_memory_alu_data_wb,
    output logic [31:0] o_memory_ld_data_wb,
    output logic [1:0]  o_memory_wb_sel_wb,
    output logic        o_memory_rd_wren_wb,
    output logic        o_memory_insn_vld_wb,
    output logic        o_memory_ctrl_wb
);

    localparam int              CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
    localparam logic [31:0]     NOP    = 32'h0000_0013;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    function automatic logic [3:0] store_bmask(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] rd);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        sb = rd[{a, 3'b000} +: 8];
        sh = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  return 32'(sb);
            3'b001:  return 32'(sh);
            3'b100:  return {24'd0, sb};
            3'b101:  return {16'd0, sh};
            default: return rd;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_load, is_store, is_branch, is_jump;
    logic       br_cond, taken;
    logic       sz_byte, sz_half, misalign, access;
    logic       req, complete, abort, stall;

    assign opcode    = i_memory_inst[6:0];
    assign funct3    = i_memory_inst[14:12];
    assign is_load   = i_memory_insn_vld && (opcode == 7'b0000011);
    assign is_store  = i_memory_insn_vld && (opcode == 7'b0100011);
    assign is_branch = i_memory_insn_vld && (opcode == 7'b1100011);
    assign is_jump   = i_memory_insn_vld && (opcode == 7'b1101111 || opcode == 7'b1100111);

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:          br_cond = i_memory_br_equal;
            3'b001:          br_cond = !i_memory_br_equal;
            3'b100, 3'b110:  br_cond = i_memory_br_less;
            3'b101, 3'b111:  br_cond = !i_memory_br_less;
            default:         br_cond = 1'b0;
        endcase
    end

    assign taken = is_jump || (is_branch && br_cond);

    // Size comes from slt_sl[1:0]: 00 byte, 01 half, anything else is treated as a word.
    assign sz_byte  = (i_memory_slt_sl[1:0] == 2'b00);
    assign sz_half  = (i_memory_slt_sl[1:0] == 2'b01);
    assign misalign = (is_load || is_store) &&
                      ((sz_half && i_memory_alu_data[0]) ||
                       (!sz_byte && !sz_half && i_memory_alu_data[1:0] != 2'b00));
    assign access   = (is_load || is_store) && !misalign;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req      = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    req = 1'b1;
                    if (i_dmem_ack) begin
                        complete = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (!access) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    req = 1'b1;
                    if (i_dmem_ack) begin
                        complete = 1'b1;
                        state_d  = S_IDLE;
                        cnt_d    = '0;
                    end else if (cnt_q == TO_CNT) begin
                        abort   = 1'b1;
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_memory_clk) begin
        if (i_memory_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall = access && !complete && !abort;

    assign o_dmem_req         = req && !i_memory_reset;
    assign o_dmem_we          = is_store;
    assign o_dmem_addr        = {i_memory_alu_data[31:2], 2'b00};
    assign o_dmem_wdata       = store_wdata(i_memory_slt_sl, i_memory_rs2_data);
    assign o_dmem_bmask       = is_store ? store_bmask(i_memory_slt_sl, i_memory_alu_data[1:0])
                                         : 4'b1111;
    assign o_memory_stall     = stall && !i_memory_reset;
    assign o_memory_flush     = taken && !i_memory_reset;
    assign o_memory_pc_sel    = taken && !i_memory_reset;
    assign o_memory_pc_target = taken ? i_memory_alu_data : 32'd0;
    assign o_memory_misalign  = misalign && !i_memory_reset;
    assign o_memory_bus_err   = abort && !i_memory_reset;
    assign o_memory_fwd_data  = i_memory_alu_data;

    logic [31:0] pc_wb_q, inst_wb_q, alu_wb_q, ld_wb_q;
    logic [1:0]  wb_sel_wb_q;
    logic        rd_wren_wb_q, vld_wb_q, ctrl_wb_q;

    // MEM/WB boundary: a stalled cycle hands WB a NOP bubble.
    always_ff @(posedge i_memory_clk) begin
        if (i_memory_reset || stall) begin
            pc_wb_q      <= '0;
            inst_wb_q    <= NOP;
            alu_wb_q     <= '0;
            ld_wb_q      <= '0;
            wb_sel_wb_q  <= '0;
            rd_wren_wb_q <= 1'b0;
            vld_wb_q     <= 1'b0;
            ctrl_wb_q    <= 1'b0;
        end else begin
            pc_wb_q      <= i_memory_pc;
            inst_wb_q    <= i_memory_inst;
            alu_wb_q     <= i_memory_alu_data;
            ld_wb_q      <= (is_load && complete)
                            ? load_extract(i_memory_slt_sl, i_memory_alu_data[1:0], i_dmem_rdata)
                            : 32'd0;
            wb_sel_wb_q  <= i_memory_wb_sel;
            rd_wren_wb_q <= i_memory_rd_wren && !misalign && !abort;
            vld_wb_q     <= i_memory_insn_vld;
            ctrl_wb_q    <= i_memory_ctrl;
        end
    end

    assign o_memory_pc_wb       = pc_wb_q;
    assign o_memory_inst_wb     = inst_wb_q;
    assign o_memory_alu_data_wb = alu_wb_q;
    assign o_memory_ld_data_wb  = ld_wb_q;
    assign o_memory_wb_sel_wb   = wb_sel_wb_q;
    assign o_memory_rd_wren_wb  = rd_wren_wb_q;
    assign o_memory_insn_vld_wb = vld_wb_q;
    assign o_memory_ctrl_wb     = ctrl_wb_q;

    logic unused_inputs;
    assign unused_inputs = i_memory_lsu_wren;

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: directed scenarios followed by random traffic, all checked against
// a cycle-level behavioural model of the MEM stage.
module tb_memory_cycle;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i, inst_i, alu_i, rs2_i, rdata_i;
    logic        vld_i, ctrl_i, beq_i, blt_i, lsuw_i, rdw_i, ack_i;
    logic [2:0]  sl_i;
    logic [1:0]  wbs_i;

    logic        req_o, we_o, stall_o, flush_o, pcsel_o, mis_o, berr_o, rdw_wb_o, vld_wb_o, ctrl_wb_o;
    logic [31:0] addr_o, wdata_o, target_o, fwd_o, pc_wb_o, inst_wb_o, alu_wb_o, ld_wb_o;
    logic [3:0]  bmask_o;
    logic [1:0]  wbs_wb_o;

    int total = 0;
    int passed = 0;
    int failed = 0;
    int waited = 0;
    logic last_stall = 1'b0;
    logic seen_berr = 1'b0;

    logic [31:0] e_pc, e_inst, e_alu, e_ld;
    logic [1:0]  e_wbs;
    logic        e_rdw, e_vld, e_ctrl;

    always #5 clk = ~clk;

    memory_cycle #(.TIMEOUT(TO)) dut (
        .i_memory_clk(clk), .i_memory_reset(rst_i),
        .i_memory_pc(pc_i), .i_memory_inst(inst_i), .i_memory_insn_vld(vld_i),
        .i_memory_ctrl(ctrl_i), .i_memory_alu_data(alu_i), .i_memory_rs2_data(rs2_i),
        .i_memory_br_equal(beq_i), .i_memory_br_less(blt_i), .i_memory_lsu_wren(lsuw_i),
        .i_memory_slt_sl(sl_i), .i_memory_wb_sel(wbs_i), .i_memory_rd_wren(rdw_i),
        .o_dmem_req(req_o), .o_dmem_we(we_o), .o_dmem_addr(addr_o), .o_dmem_wdata(wdata_o),
        .o_dmem_bmask(bmask_o), .i_dmem_ack(ack_i), .i_dmem_rdata(rdata_i),
        .o_memory_stall(stall_o), .o_memory_flush(flush_o), .o_memory_pc_sel(pcsel_o),
        .o_memory_pc_target(target_o), .o_memory_misalign(mis_o), .o_memory_bus_err(berr_o),
        .o_memory_fwd_data(fwd_o), .o_memory_pc_wb(pc_wb_o), .o_memory_inst_wb(inst_wb_o),
        .o_memory_alu_data_wb(alu_wb_o), .o_memory_ld_data_wb(ld_wb_o),
        .o_memory_wb_sel_wb(wbs_wb_o), .o_memory_rd_wren_wb(rdw_wb_o),
        .o_memory_insn_vld_wb(vld_wb_o), .o_memory_ctrl_wb(ctrl_wb_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
        return {17'd0, f3, 5'd5, opc};
    endfunction

    task automatic set_in(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [2:0] sl, input logic ack, input logic [31:0] rd);
        pc_i    = pc_i + 32'd4;
        inst_i  = inst;
        vld_i   = 1'b1;
        ctrl_i  = 1'b0;
        alu_i   = alu;
        rs2_i   = rs2;
        beq_i   = 1'b0;
        blt_i   = 1'b0;
        sl_i    = sl;
        wbs_i   = 2'b01;
        rdw_i   = 1'b1;
        lsuw_i  = (inst[6:0] == 7'h23);
        ack_i   = ack;
        rdata_i = rd;
    endtask

    // One clock: checks combinational outputs mid-cycle, then the MEM/WB registers after the edge.
    task automatic run_cycle();
        logic [6:0]  opc;
        logic        ld, st, br, jp, cond, tk, mis, acc, done, abt, stl;
        logic [31:0] nb, sh, w, v, bm, wd;
        #2;
        opc  = inst_i[6:0];
        ld   = vld_i && opc == 7'h03;
        st   = vld_i && opc == 7'h23;
        br   = vld_i && opc == 7'h63;
        jp   = vld_i && (opc == 7'h6f || opc == 7'h67);
        case (inst_i[14:12])
            3'd0:       cond = beq_i;
            3'd1:       cond = !beq_i;
            3'd4, 3'd6: cond = blt_i;
            3'd5, 3'd7: cond = !blt_i;
            default:    cond = 1'b0;
        endcase
        tk   = jp || (br && cond);
        nb   = (sl_i[1:0] == 2'd0) ? 32'd1 : (sl_i[1:0] == 2'd1) ? 32'd2 : 32'd4;
        mis  = (ld || st) && (alu_i % nb != 0);
        acc  = (ld || st) && !mis;
        done = acc && ack_i;
        abt  = acc && !ack_i && waited == TO;
        stl  = acc && !done && !abt;
        sh   = 32'd8 * (alu_i % 4);
        if (rst_i) begin
            chk("rst_req", {31'd0, req_o}, 32'd0);
            chk("rst_stall", {31'd0, stall_o}, 32'd0);
            chk("rst_flush", {31'd0, flush_o}, 32'd0);
            chk("rst_pcsel", {31'd0, pcsel_o}, 32'd0);
            chk("rst_misalign", {31'd0, mis_o}, 32'd0);
            chk("rst_buserr", {31'd0, berr_o}, 32'd0);
        end else begin
            seen_berr = seen_berr | berr_o;
            chk("req", {31'd0, req_o}, {31'd0, acc});
            chk("stall", {31'd0, stall_o}, {31'd0, stl});
            chk("flush", {31'd0, flush_o}, {31'd0, tk});
            chk("pc_sel", {31'd0, pcsel_o}, {31'd0, tk});
            chk("misalign", {31'd0, mis_o}, {31'd0, mis});
            chk("bus_err", {31'd0, berr_o}, {31'd0, abt});
            if (tk) chk("pc_target", target_o, alu_i);
            if (acc) begin
                if (!st) begin
                    bm = 32'hF;
                end else if (nb == 1) begin
                    bm = 32'd1 << (alu_i % 4);
                end else if (nb == 2) begin
                    bm = 32'd3 << (alu_i % 4);
                end else begin
                    bm = 32'hF;
                end
                wd = (nb == 1) ? (rs2_i & 32'hFF) * 32'h0101_0101 :
                     (nb == 2) ? (rs2_i & 32'hFFFF) * 32'h0001_0001 : rs2_i;
                chk("addr", addr_o, alu_i - (alu_i % 4));
                chk("we", {31'd0, we_o}, {31'd0, st});
                chk("bmask", {28'd0, bmask_o}, bm);
                if (st) chk("wdata", wdata_o, wd);
            end
        end
        chk("fwd", fwd_o, alu_i);

        if (rst_i || stl) begin
            e_pc = 0; e_inst = 32'h13; e_alu = 0; e_ld = 0; e_wbs = 0;
            e_rdw = 0; e_vld = 0; e_ctrl = 0;
        end else begin
            e_pc = pc_i; e_inst = inst_i; e_alu = alu_i; e_wbs = wbs_i;
            e_rdw = rdw_i && !mis && !abt; e_vld = vld_i; e_ctrl = ctrl_i;
            v = 0;
            if (ld && done) begin
                w = rdata_i >> sh;
                case (sl_i)
                    3'd0: begin v = w & 32'hFF; if (v >= 128) v = v - 256; end
                    3'd1: begin v = w & 32'hFFFF; if (v >= 32768) v = v - 65536; end
                    3'd4: v = w & 32'hFF;
                    3'd5: v = w & 32'hFFFF;
                    default: v = rdata_i;
                endcase
            end
            e_ld = v;
        end
        waited     = (rst_i || !stl) ? 0 : waited + 1;
        last_stall = stl && !rst_i;

        @(posedge clk);
        #1;
        chk("pc_wb", pc_wb_o, e_pc);
        chk("inst_wb", inst_wb_o, e_inst);
        chk("alu_wb", alu_wb_o, e_alu);
        chk("ld_wb", ld_wb_o, e_ld);
        chk("wbsel_wb", {30'd0, wbs_wb_o}, {30'd0, e_wbs});
        chk("rdwren_wb", {31'd0, rdw_wb_o}, {31'd0, e_rdw});
        chk("vld_wb", {31'd0, vld_wb_o}, {31'd0, e_vld});
        chk("ctrl_wb", {31'd0, ctrl_wb_o}, {31'd0, e_ctrl});
    endtask

    initial begin
        int stalls;
        logic [6:0] opcs [7];
        opcs[0] = 7'h03; opcs[1] = 7'h23; opcs[2] = 7'h63; opcs[3] = 7'h6f;
        opcs[4] = 7'h67; opcs[5] = 7'h13; opcs[6] = 7'h33;
        pc_i = 32'h1000;

        // Reset with an aligned, acked load presented.
        rst_i = 1'b1;
        set_in(mk(7'h03, 3'd2), 32'h100, 32'd0, 3'd2, 1'b1, 32'h1234_5678);
        run_cycle();
        run_cycle();
        chk("reset_inst_wb", inst_wb_o, 32'h13);
        rst_i = 1'b0;

        // LW acked in the request cycle.
        set_in(mk(7'h03, 3'd2), 32'h100, 32'd0, 3'd2, 1'b1, 32'hDEAD_BEEF);
        run_cycle();
        chk("lw_ld_data", ld_wb_o, 32'hDEAD_BEEF);
        chk("lw_rd_wren", {31'd0, rdw_wb_o}, 32'd1);

        // LB at byte 3, acked after three waiting cycles.
        set_in(mk(7'h03, 3'd0), 32'h103, 32'd0, 3'd0, 1'b0, 32'h0);
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            stalls += int'(last_stall);
        end
        chk("lb_stalls", stalls, 3);
        ack_i = 1'b1; rdata_i = 32'h8000_0000;
        run_cycle();
        chk("lb_ld_data", ld_wb_o, 32'hFFFF_FF80);

        // SH to the upper half.
        set_in(mk(7'h23, 3'd1), 32'h202, 32'h0000_ABCD, 3'd1, 1'b1, 32'h0);
        #1;
        chk("sh_bmask", {28'd0, bmask_o}, 32'hC);
        chk("sh_wdata", wdata_o, 32'hABCD_ABCD);
        chk("sh_we", {31'd0, we_o}, 32'd1);
        chk("sh_addr", addr_o, 32'h200);
        run_cycle();

        // BNE taken, BEQ not taken.
        set_in(mk(7'h63, 3'd1), 32'h400, 32'd0, 3'd0, 1'b0, 32'h0);
        #1;
        chk("bne_pcsel", {31'd0, pcsel_o}, 32'd1);
        chk("bne_flush", {31'd0, flush_o}, 32'd1);
        chk("bne_target", target_o, 32'h400);
        run_cycle();
        set_in(mk(7'h63, 3'd0), 32'h400, 32'd0, 3'd0, 1'b0, 32'h0);
        #1;
        chk("beq_pcsel", {31'd0, pcsel_o}, 32'd0);
        run_cycle();

        // Misaligned LW, then an LW that is never acked.
        set_in(mk(7'h03, 3'd2), 32'h102, 32'd0, 3'd2, 1'b1, 32'h0);
        #1;
        chk("mis_flag", {31'd0, mis_o}, 32'd1);
        chk("mis_req", {31'd0, req_o}, 32'd0);
        run_cycle();
        chk("mis_rd_wren", {31'd0, rdw_wb_o}, 32'd0);
        set_in(mk(7'h03, 3'd2), 32'h300, 32'd0, 3'd2, 1'b0, 32'h0);
        stalls = 0;
        seen_berr = 1'b0;
        for (int i = 0; i < TO + 1; i++) begin
            run_cycle();
            stalls += int'(last_stall);
        end
        chk("timeout_stalls", stalls, TO);
        chk("timeout_buserr", {31'd0, seen_berr}, 32'd1);
        chk("timeout_rd_wren", {31'd0, rdw_wb_o}, 32'd0);

        // Reset while waiting, then a fresh acked access must be served from IDLE.
        set_in(mk(7'h03, 3'd2), 32'h500, 32'd0, 3'd2, 1'b0, 32'h0);
        run_cycle();
        run_cycle();
        rst_i = 1'b1;
        run_cycle();
        chk("wait_rst_inst", inst_wb_o, 32'h13);
        rst_i = 1'b0;
        set_in(mk(7'h13, 3'd0), 32'h500, 32'd0, 3'd2, 1'b1, 32'h5555_AAAA);
        run_cycle();
        set_in(mk(7'h03, 3'd2), 32'h500, 32'd0, 3'd2, 1'b1, 32'h0BAD_F00D);
        run_cycle();
        chk("post_rst_ld", ld_wb_o, 32'h0BAD_F00D);

        // Random traffic; instruction inputs only advance when the stage is not stalled.
        for (int n = 0; n < 400; n++) begin
            if (!last_stall) begin
                logic [6:0] opc;
                logic [2:0] f3;
                opc = opcs[$urandom_range(0, 6)];
                f3  = 3'($urandom_range(0, 7));
                if (opc == 7'h23) f3 = 3'($urandom_range(0, 2));
                set_in(mk(opc, f3), $urandom, $urandom, f3, 1'b0, 32'h0);
                vld_i  = ($urandom_range(0, 9) != 0);
                ctrl_i = 1'($urandom_range(0, 1));
                beq_i  = 1'($urandom_range(0, 1));
                blt_i  = 1'($urandom_range(0, 1));
                wbs_i  = 2'($urandom_range(0, 3));
                rdw_i  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 0) alu_i[1:0] = 2'b00;
            end
            ack_i   = ($urandom_range(0, 3) == 0);
            rdata_i = $urandom;
            rst_i   = ($urandom_range(0, 63) == 0);
            run_cycle();
        end
        rst_i = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 Clocking: one clock; reset is synchronous and active-high; ports i_memory_clk, i_memory_reset.
REQ-002 Parameter: TIMEOUT, default 15, max cycles to wait for i_dmem_ack before abort.
REQ-003 i_memory_clk  in  1  clock; i_memory_reset  in  1  sync active-high reset.
REQ-004 EX/MEM inputs, all in: i_memory_pc 32, i_memory_inst 32, i_memory_insn_vld 1, i_memory_ctrl 1, i_memory_alu_data 32 (address/branch target/result), i_memory_rs2_data 32 (store data), i_memory_br_equal 1, i_memory_br_less 1, i_memory_lsu_wren 1, i_memory_slt_sl 3 (funct3 size/sign), i_memory_wb_sel 2, i_memory_rd_wren 1.
REQ-005 Data bus: o_dmem_req out 1; o_dmem_we out 1; o_dmem_addr out 32 (word-aligned); o_dmem_wdata out 32; o_dmem_bmask out 4; i_dmem_ack in 1; i_dmem_rdata in 32.
REQ-006 Hazard/redirect: o_memory_stall out 1; o_memory_flush out 1; o_memory_pc_sel out 1; o_memory_pc_target out 32; o_memory_misalign out 1; o_memory_bus_err out 1; o_memory_fwd_data out 32 (= i_memory_alu_data, combinational).
REQ-007 MEM/WB outputs: o_memory_pc_wb 32, o_memory_inst_wb 32, o_memory_alu_data_wb 32, o_memory_ld_data_wb 32, o_memory_wb_sel_wb 2, o_memory_rd_wren_wb 1, o_memory_insn_vld_wb 1, o_memory_ctrl_wb 1.

Function
REQ-008 Classify from i_memory_inst[6:0] when i_memory_insn_vld=1: load 0000011, store 0100011, branch 1100011, jump 1101111/1100111; else none.
REQ-009 Branch taken per funct3: 000 eq, 001 !eq, 100/110 less, 101/111 !less; jumps always taken.
REQ-010 Taken: o_memory_pc_sel=1, o_memory_pc_target=i_memory_alu_data, o_memory_flush=1, combinational, same cycle; otherwise all 0 / target don't-care.
REQ-011 Misaligned: halfword with addr[0]=1 or word with addr[1:0]!=0 -> no o_dmem_req, o_memory_misalign=1 that cycle, instruction retires with rd_wren=0, no stall.
REQ-012 FSM states IDLE, WAIT. IDLE: aligned load/store -> o_dmem_req=1; ack same cycle -> complete, stay IDLE; no ack -> WAIT, counter=1.
REQ-013 WAIT: o_dmem_req=1 with addr/we/wdata/bmask stable; ack -> complete, IDLE; counter reaching TIMEOUT without ack -> abort, o_memory_bus_err=1 one cycle, IDLE, retire with rd_wren=0.
REQ-014 o_memory_stall=1 whenever a load/store is requested and neither complete nor aborted this cycle; upstream holds inputs stable while stall=1.
REQ-015 o_dmem_addr={alu[31:2],2'b00}; o_dmem_we=1 for stores only.
REQ-016 Store: SB bmask=0001<<addr[1:0], wdata=byte replicated x4; SH bmask=0011 (addr[1]=0) or 1100, wdata=halfword replicated x2; SW bmask=1111, wdata=rs2. Loads bmask=1111.
REQ-017 Load extract by addr[1:0]: 000 LB sign-ext byte, 001 LH sign-ext half, 010 LW word, 100 LBU zero-ext, 101 LHU zero-ext; other codes -> word.
REQ-018 MEM/WB register updates every clock: stall=1 -> bubble (inst 0x00000013, insn_vld 0, rd_wren 0, other fields 0); else capture inputs, ld_data=extracted load (0 for non-loads), rd_wren masked per REQ-011/REQ-013.
REQ-019 Load data captured on the ack cycle; ack while IDLE and no request is ignored.
REQ-020 o_memory_flush never asserted for a bubble (insn_vld=0).

Reset
REQ-021 Reset: FSM IDLE, counter 0; MEM/WB regs 0 except o_memory_inst_wb=0x00000013; o_dmem_req, stall, flush, pc_sel, misalign, bus_err forced 0 while reset asserted.
REQ-022 Reset during WAIT abandons access: req 0 in reset cycle, no bus_err, IDLE after.

Verification
REQ-023 LW alu=0x100, ack same cycle, rdata=0xDEADBEEF -> no stall; next cycle ld_data_wb=0xDEADBEEF, rd_wren_wb=1.
REQ-024 LB alu=0x103, ack after 3 cycles, rdata=0x80000000 -> stall 3 cycles, 3 bubbles; then ld_data_wb=0xFFFFFF80.
REQ-025 SH alu=0x202, rs2=0x0000ABCD -> bmask=1100, wdata=0xABCDABCD, we=1, addr=0x200.
REQ-026 BNE br_equal=0, alu=0x400 -> same cycle pc_sel=1, flush=1, target=0x400; BEQ br_equal=0 -> pc_sel=0.
REQ-027 LW alu=0x102 -> misalign=1, no req, rd_wren_wb=0; LW never acked -> stall TIMEOUT cycles, bus_err pulse.
REQ-028 Reset asserted in WAIT -> req 0 that cycle, inst_wb=0x13, bus_err 0, IDLE afterward.
